hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use stall unit.
- Tracks outstanding writes per architectural register so the core can use variable-latency loads and multi-cycle (vector/long) ops.
- Sits between decode (ID) and dispatch. Drives the pipeline stall from per-register pending counters, with optional same-cycle writeback bypass, a deadlock watchdog and error flags.

Parameters:
- NUM_REGS, 32, number of architectural registers tracked; register 0 is never tracked.
- ADDR_W, 5, register address width; NUM_REGS <= 2**ADDR_W.
- NUM_SRC, 3, number of source operands checked per decoded instruction.
- MAX_PENDING, 3, maximum outstanding writes per register; counter width CNT_W = $clog2(MAX_PENDING+1).
- WB_BYPASS, 1, when 1, a writeback retiring the last pending write to a register does not stall a reader in the same cycle.
- TIMEOUT, 256, consecutive stall cycles before deadlock is flagged; 0 disables the watchdog.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- id_src_addr  in  NUM_SRC*ADDR_W  packed source register addresses; source i occupies bits [i*ADDR_W +: ADDR_W].
- id_src_used  in  NUM_SRC  per-source valid flag.
- id_issue_valid  in  1  the ID instruction attempts dispatch this cycle.
- id_issue_long  in  1  the dispatching instruction writes rd with variable latency (load, vector, mul/div).
- id_rd_addr  in  ADDR_W  destination of the dispatching instruction.
- wb_valid  in  1  a long-latency result retires this cycle.
- wb_rd_addr  in  ADDR_W  destination of the retiring result.
- stall_pipeline  out  1  combinational stall to ID/IF.
- pending_mask  out  NUM_REGS  bit r = (count[r] != 0).
- busy  out  1  OR of pending_mask.
- err_underflow  out  1  sticky; wb_valid for a register whose count is 0.
- deadlock  out  1  sticky; watchdog expired.

Behaviour:
- Reset: all counts 0, err_underflow=0, deadlock=0, stall counter 0. While rst=1, stall_pipeline=0.
- src_hit[i] = id_src_used[i] && addr!=0 && count[addr]!=0.
  - If WB_BYPASS=1, src_hit[i] is also suppressed when wb_valid && wb_rd_addr==addr && count[addr]==1.
- full_hit = id_issue_valid && id_issue_long && id_rd_addr!=0 && count[id_rd_addr]==MAX_PENDING.
  - A simultaneous wb_valid to that register does not clear full_hit.
- stall_pipeline = OR(src_hit) | full_hit. Purely combinational, zero latency.
- Accepted issue: inc = id_issue_valid && id_issue_long && id_rd_addr!=0 && !stall_pipeline.
- Retire: dec = wb_valid && wb_rd_addr!=0 && count[wb_rd_addr]!=0.
- Counter update, registered on the next clk edge:
  - inc and dec to the same register: count unchanged.
  - Different registers: each updated independently.
  - Register 0 and addresses >= NUM_REGS are ignored for inc/dec and never hit.
- Underflow: wb_valid, wb_rd_addr!=0, count==0 -> no change to counts; err_underflow set on the next edge. Cleared only by rst.
- Watchdog: stall_cnt increments each cycle stall_pipeline=1 and resets to 0 on any cycle it is 0. When stall_cnt reaches TIMEOUT-1 while stalled, deadlock is set on that edge. stall_cnt saturates.
- pending_mask and busy are derived from registered counts; they lag an accepted issue by one cycle.
- Results are assumed to return in order per register; in-order WAW with counts > 1 is permitted.
- Reset mid-operation discards all pending state. The surrounding pipeline is flushed by the same rst.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: adds outputs stat_stall_cycles [31:0] and stat_full_stalls [31:0].
  - stat_stall_cycles counts cycles with stall_pipeline=1.
  - stat_full_stalls counts cycles where full_hit=1.
  - Both wrap at 2**32 and reset to 0.
- Not defined: those ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load then use: issue long rd=5 at cycle 0; ID reads x5 at cycles 1-3 with wb rd=5 at cycle 3 -> stall=1 at cycles 1-2; stall=0 at cycle 3 (WB_BYPASS=1); pending_mask[5]=0 from cycle 4.
- Register 0: issue long rd=0, then read x0 -> no stall, pending_mask=0, busy=0.
- Saturation: three accepted long issues to rd=7 give count=3; a fourth issue to rd=7 -> stall=1 and count stays 3. One wb rd=7 gives count=2 on the next edge, after which the issue is accepted.
- Simultaneous events: with count[9]=1, same-cycle issue long rd=9 and wb rd=9 -> count[9]=1 after the edge; stall on a read of x9 the next cycle.
- Underflow: wb rd=12 with count 0 -> err_underflow=1 next cycle and counts unchanged; rst=1 for one cycle clears it.
- Watchdog with TIMEOUT=4: hold a src on a pending register with no wb -> deadlock=1 after the 4th consecutive stall cycle and stays set after stall drops.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard between decode and dispatch: stalls readers of
// registers with outstanding long-latency writes. Optional counters via HAZARD_STATS_EN.
module hazard_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 5,
  parameter int NUM_SRC     = 3,
  parameter int MAX_PENDING = 3,
  parameter bit WB_BYPASS   = 1'b1,
  parameter int TIMEOUT     = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic                      id_issue_valid,
  input  logic                      id_issue_long,
  input  logic [ADDR_W-1:0]         id_rd_addr,
  input  logic                      wb_valid,
  input  logic [ADDR_W-1:0]         wb_rd_addr,
  output logic                      stall_pipeline,
  output logic [NUM_REGS-1:0]       pending_mask,
  output logic                      busy,
  output logic                      err_underflow,
  output logic                      deadlock
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]               stat_stall_cycles,
  output logic [31:0]               stat_full_stalls
`endif
);

  localparam int CNT_W = $clog2(MAX_PENDING + 1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_SRC-1:0]  src_hit;
  logic [CNT_W-1:0]    rd_cnt, wb_cnt;
  logic                issue_req, full_hit, inc, dec, underflow;
  logic [NUM_REGS-1:0] inc_vec, dec_vec;

  // Register 0 and out-of-range addresses are never tracked.
  function automatic logic tracked(input logic [ADDR_W-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  function automatic logic [CNT_W-1:0] cnt_of(input logic [ADDR_W-1:0] a);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int r = 1; r < NUM_REGS; r++)
      if (a == ADDR_W'(r)) c = cnt[r];
    return c;
  endfunction

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  c;
    logic              bypass;
    assign addr   = id_src_addr[gi*ADDR_W +: ADDR_W];
    assign c      = cnt_of(addr);
    assign bypass = WB_BYPASS && wb_valid && (wb_rd_addr == addr) && (c == CNT_W'(1));
    assign src_hit[gi] = id_src_used[gi] && tracked(addr) && (c != '0) && !bypass;
  end

  always_comb begin
    rd_cnt    = cnt_of(id_rd_addr);
    wb_cnt    = cnt_of(wb_rd_addr);
    issue_req = id_issue_valid && id_issue_long && tracked(id_rd_addr);
    // A same-cycle retire to the full register does not open a slot until the next edge.
    full_hit  = issue_req && (rd_cnt == CNT_W'(MAX_PENDING));
    stall_pipeline = !rst && ((|src_hit) || full_hit);
    inc       = issue_req && !stall_pipeline;
    dec       = wb_valid && tracked(wb_rd_addr) && (wb_cnt != '0);
    underflow = wb_valid && tracked(wb_rd_addr) && (wb_cnt == '0);
    inc_vec   = '0;
    dec_vec   = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_vec[r] = inc && (id_rd_addr == ADDR_W'(r));
      dec_vec[r] = dec && (wb_rd_addr == ADDR_W'(r));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r])      cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec_vec[r] && !inc_vec[r]) cnt[r] <= cnt[r] - CNT_W'(1);
      end
      if (underflow) err_underflow <= 1'b1;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) pending_mask[r] = (cnt[r] != '0);
    busy = |pending_mask;
  end

  if (TIMEOUT > 0) begin : g_wd
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] stall_cnt;
    // Counter parks at TIMEOUT-1; the sticky flag carries the information from there.
    always_ff @(posedge clk) begin
      if (rst) begin
        stall_cnt <= '0;
        deadlock  <= 1'b0;
      end else if (stall_pipeline) begin
        if (stall_cnt == TW'(TIMEOUT - 1)) deadlock <= 1'b1;
        else                               stall_cnt <= stall_cnt + TW'(1);
      end else begin
        stall_cnt <= '0;
      end
    end
  end else begin : g_no_wd
    assign deadlock = 1'b0;
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cycles <= '0;
      stat_full_stalls  <= '0;
    end else begin
      if (stall_pipeline) stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (full_hit)       stat_full_stalls  <= stat_full_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table for the main sequences plus a
// hand-written watchdog sequence, built with TIMEOUT=4.
module tb_hazard_scoreboard;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NS = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS*AW-1:0] id_src_addr;
  logic [NS-1:0]   id_src_used;
  logic            id_issue_valid, id_issue_long;
  logic [AW-1:0]   id_rd_addr;
  logic            wb_valid;
  logic [AW-1:0]   wb_rd_addr;
  logic            stall_pipeline;
  logic [NR-1:0]   pending_mask;
  logic            busy, err_underflow, deadlock;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NUM_REGS(NR), .ADDR_W(AW), .NUM_SRC(NS), .MAX_PENDING(3),
    .WB_BYPASS(1'b1), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .id_src_addr(id_src_addr), .id_src_used(id_src_used),
    .id_issue_valid(id_issue_valid), .id_issue_long(id_issue_long),
    .id_rd_addr(id_rd_addr), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr),
    .stall_pipeline(stall_pipeline), .pending_mask(pending_mask), .busy(busy),
    .err_underflow(err_underflow), .deadlock(deadlock)
  );

  typedef struct {
    logic        rst;
    logic        iv, il;
    logic [4:0]  rd;
    int          sidx;
    logic [4:0]  src;
    logic        used;
    logic        wv;
    logic [4:0]  wrd;
    logic        e_stall;
    logic [31:0] e_mask;
    logic        e_err;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(logic r, logic iv, logic il, logic [4:0] rd, int sidx,
                              logic [4:0] src, logic used, logic wv, logic [4:0] wrd,
                              logic es, logic [31:0] em, logic ee);
    vec_t v;
    v.rst = r; v.iv = iv; v.il = il; v.rd = rd; v.sidx = sidx; v.src = src;
    v.used = used; v.wv = wv; v.wrd = wrd; v.e_stall = es; v.e_mask = em; v.e_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs just after a rising edge; return at the following falling edge.
  task automatic apply(input vec_t v);
    @(posedge clk);
    #1;
    rst            = v.rst;
    id_issue_valid = v.iv;
    id_issue_long  = v.il;
    id_rd_addr     = v.rd;
    id_src_addr    = '0;
    id_src_addr[v.sidx*AW +: AW] = v.src;
    id_src_used    = v.used ? NS'(1 << v.sidx) : '0;
    wb_valid       = v.wv;
    wb_rd_addr     = v.wrd;
    @(negedge clk);
  endtask

  localparam logic [31:0] B3 = 32'h1 << 3;
  localparam logic [31:0] B5 = 32'h1 << 5;
  localparam logic [31:0] B7 = 32'h1 << 7;
  localparam logic [31:0] B9 = 32'h1 << 9;
  localparam logic [31:0] B20 = 32'h1 << 20;

  initial begin
    //            rst iv il rd sidx src used wv wrd  stall mask err
    tbl[0]  = mk(0, 1, 1, 5, 0, 0, 0, 0, 0,  0, 0,  0); // load-use
    tbl[1]  = mk(0, 0, 0, 0, 0, 5, 1, 0, 0,  1, B5, 0);
    tbl[2]  = mk(0, 0, 0, 0, 2, 5, 1, 0, 0,  1, B5, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 5, 1, 1, 5,  0, B5, 0);
    tbl[4]  = mk(0, 0, 0, 0, 0, 5, 1, 0, 0,  0, 0,  0);
    tbl[5]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0,  0, 0,  0); // x0
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0,  0);
    tbl[7]  = mk(0, 1, 1, 7, 0, 0, 0, 0, 0,  0, 0,  0); // saturation
    tbl[8]  = mk(0, 1, 1, 7, 0, 0, 0, 0, 0,  0, B7, 0);
    tbl[9]  = mk(0, 1, 1, 7, 0, 0, 0, 0, 0,  0, B7, 0);
    tbl[10] = mk(0, 1, 1, 7, 0, 0, 0, 0, 0,  1, B7, 0);
    tbl[11] = mk(0, 1, 1, 7, 0, 0, 0, 1, 7,  1, B7, 0);
    tbl[12] = mk(0, 1, 1, 7, 0, 0, 0, 0, 0,  0, B7, 0);
    tbl[13] = mk(0, 1, 1, 7, 0, 0, 0, 0, 0,  1, B7, 0);
    tbl[14] = mk(0, 1, 0, 7, 0, 0, 0, 1, 7,  0, B7, 0); // short issue not tracked
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7,  0, B7, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 1, 7,  0, B7, 0);
    tbl[17] = mk(0, 0, 0, 0, 1, 7, 1, 0, 0,  0, 0,  0);
    tbl[18] = mk(0, 1, 1, 9, 0, 0, 0, 0, 0,  0, 0,  0); // simultaneous inc/dec
    tbl[19] = mk(0, 1, 1, 9, 0, 0, 0, 1, 9,  0, B9, 0);
    tbl[20] = mk(0, 0, 0, 0, 1, 9, 1, 0, 0,  1, B9, 0);
    tbl[21] = mk(0, 0, 0, 0, 1, 9, 1, 1, 9,  0, B9, 0);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0,  0); // underflow
    tbl[24] = mk(0, 1, 1, 3, 0, 0, 0, 0, 0,  0, 0,  1);
    tbl[25] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0,  0, B3, 1);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0);
    tbl[27] = mk(0, 0, 0, 0, 0, 3, 1, 0, 0,  0, 0,  0);

    rst = 1'b1; id_src_addr = '0; id_src_used = '0; id_issue_valid = 1'b0;
    id_issue_long = 1'b0; id_rd_addr = '0; wb_valid = 1'b0; wb_rd_addr = '0;

    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("reset_stall", 32'(stall_pipeline), 0);
    chk("reset_mask", pending_mask, 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_err", 32'(err_underflow), 0);
    chk("reset_deadlock", 32'(deadlock), 0);

    for (int i = 0; i < 28; i++) begin
      apply(tbl[i]);
      chk($sformatf("v%0d_stall", i), 32'(stall_pipeline), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_mask", i), pending_mask, tbl[i].e_mask);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_mask != 0));
      chk($sformatf("v%0d_err", i), 32'(err_underflow), 32'(tbl[i].e_err));
      chk($sformatf("v%0d_deadlock", i), 32'(deadlock), 0);
    end

    // Watchdog: four consecutive stall cycles set deadlock on the fourth edge.
    apply(mk(0, 1, 1, 20, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 4; k++) begin
      apply(mk(0, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0, 0));
      chk($sformatf("wd%0d_stall", k), 32'(stall_pipeline), 1);
      chk($sformatf("wd%0d_mask", k), pending_mask, B20);
      chk($sformatf("wd%0d_deadlock", k), 32'(deadlock), 0);
    end
    apply(mk(0, 0, 0, 0, 0, 20, 1, 1, 20, 0, 0, 0));
    chk("wd_release_stall", 32'(stall_pipeline), 0);
    chk("wd_set_deadlock", 32'(deadlock), 1);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("wd_sticky_deadlock", 32'(deadlock), 1);
    chk("wd_idle_mask", pending_mask, 0);
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("wd_reset_clears", 32'(deadlock), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
